// File: rtl/counter_gen_pkg.sv
// Shared types and constants for the multi-channel counter generator.
package counter_gen_pkg;

  typedef enum logic [1:0] {
    ModeUpWrap   = 2'b00,
    ModeDownWrap = 2'b01,
    ModeUpMod    = 2'b10,
    ModeOneShot  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    SelCtrl     = 2'b00,
    SelLimit    = 2'b01,
    SelPrescale = 2'b10,
    SelLoad     = 2'b11
  } cfg_sel_t;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlModeMsb = 2;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned ch_idx_w(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/counter_gen_if.sv
// Configuration write bus shared by the counter generator and its driver.
interface counter_gen_if
  import counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);

  localparam int unsigned ChW = ch_idx_w(CHANNELS);

  logic             cfg_we;
  logic [ChW-1:0]   cfg_ch;
  cfg_sel_t         cfg_sel;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_sel,
    output cfg_data
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_sel,
    input cfg_data
  );

endinterface

// File: rtl/counter_gen_chan.sv
// One counter channel: config registers, prescaler, mode logic and terminal-count pulse.
module counter_gen_chan
  import counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  cfg_sel_t         i_sel,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_running
);

  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_limit, w_limit_d;
  logic [WIDTH-1:0] r_prescale, w_prescale_d;
  logic [WIDTH-1:0] r_pre_cnt, w_pre_cnt_d;
  logic             r_en, w_en_d;
  mode_t            r_mode, w_mode_d;
  logic             r_tc, w_tc_d;
  logic             w_tick;

  assign w_tick = r_en && (r_pre_cnt == r_prescale);

  always_comb begin
    w_count_d    = r_count;
    w_limit_d    = r_limit;
    w_prescale_d = r_prescale;
    w_pre_cnt_d  = r_pre_cnt;
    w_en_d       = r_en;
    w_mode_d     = r_mode;
    w_tc_d       = 1'b0;

    if (r_en) begin
      w_pre_cnt_d = w_tick ? '0 : r_pre_cnt + 1'b1;
    end

    if (w_tick) begin
      unique case (r_mode)
        ModeUpWrap: begin
          w_count_d = r_count + 1'b1;
          w_tc_d    = (r_count == '1);
        end
        ModeDownWrap: begin
          w_count_d = r_count - 1'b1;
          w_tc_d    = (r_count == '0);
        end
        ModeUpMod: begin
          if (r_count >= r_limit) begin
            w_count_d = '0;
            w_tc_d    = 1'b1;
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
        ModeOneShot: begin
          if (r_count >= r_limit) begin
            w_en_d = 1'b0;
            w_tc_d = 1'b1;
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Register writes override the tick result, including a one-shot auto-disable.
    if (i_we) begin
      unique case (i_sel)
        SelCtrl: begin
          w_en_d      = i_data[CtrlEnBit];
          w_mode_d    = mode_t'(i_data[CtrlModeMsb:CtrlModeLsb]);
          w_pre_cnt_d = '0;
        end
        SelLimit:    w_limit_d    = i_data;
        SelPrescale: w_prescale_d = i_data;
        SelLoad: begin
          w_count_d   = i_data;
          w_pre_cnt_d = '0;
          w_tc_d      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_limit    <= '1;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_en       <= 1'b0;
      r_mode     <= ModeUpWrap;
      r_tc       <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_limit    <= w_limit_d;
      r_prescale <= w_prescale_d;
      r_pre_cnt  <= w_pre_cnt_d;
      r_en       <= w_en_d;
      r_mode     <= w_mode_d;
      r_tc       <= w_tc_d;
    end
  end

  assign o_count   = r_count;
  assign o_tc      = r_tc;
  assign o_running = r_en;

endmodule

// File: rtl/counter_gen.sv
// Multi-channel counter generator: decodes config writes and packs per-channel outputs.
module counter_gen
  import counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  counter_gen_if.slave              cfg,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       running
);

  localparam int unsigned ChW = ch_idx_w(CHANNELS);

  logic [CHANNELS-1:0] w_we;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Indices at or above CHANNELS match no strobe, so such writes are dropped.
    assign w_we[i] = cfg.cfg_we && (cfg.cfg_ch == ChW'(i));

    counter_gen_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we[i]),
      .i_sel    (cfg.cfg_sel),
      .i_data   (cfg.cfg_data),
      .o_count  (out[i*WIDTH +: WIDTH]),
      .o_tc     (tc[i]),
      .o_running(running[i])
    );
  end

endmodule

// File: tb/tb_counter_gen.sv
// Directed scoreboard bench for counter_gen; five channels so an out-of-range index exists.
module tb_counter_gen;
  import counter_gen_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 5;

  logic            clk;
  logic            rst;
  logic [CH*W-1:0] out;
  logic [CH-1:0]   tc;
  logic [CH-1:0]   running;

  counter_gen_if #(.WIDTH(W), .CHANNELS(CH)) cfg_bus ();

  counter_gen #(
    .WIDTH   (W),
    .CHANNELS(CH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg    (cfg_bus),
    .out    (out),
    .tc     (tc),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         ch;
    logic [7:0] cnt;
    logic       t;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic wr(input int ch, input cfg_sel_t sel, input logic [7:0] data);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_ch   = 3'(ch);
    cfg_bus.cfg_sel  = sel;
    cfg_bus.cfg_data = data;
  endtask

  task automatic wr_now(input int ch, input cfg_sel_t sel, input logic [7:0] data);
    wr(ch, sel, data);
    @(posedge clk);
    #1;
    cfg_bus.cfg_we = 1'b0;
  endtask

  // Expected channel state after the next clock edge is queued, then checked once it lands.
  task automatic step(input string tag, input int ch, input logic [7:0] cnt, input logic t,
                      input logic r);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.cnt = cnt;
    e.t   = t;
    e.r   = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cfg_bus.cfg_we = 1'b0;
    e = exp_q.pop_front();
    check_val({e.tag, "_cnt"}, 64'(out[e.ch*W +: W]), 64'(e.cnt));
    check_val({e.tag, "_tc"}, 64'(tc[e.ch]), 64'(e.t));
    check_val({e.tag, "_run"}, 64'(running[e.ch]), 64'(e.r));
  endtask

  initial begin
    logic [7:0] dn_seq [7];
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    cfg_bus.cfg_we   = 1'b0;
    cfg_bus.cfg_ch   = '0;
    cfg_bus.cfg_sel  = SelCtrl;
    cfg_bus.cfg_data = '0;

    #12;
    check_val("rst_out", 64'(out), 64'd0);
    check_val("rst_tc", 64'(tc), 64'd0);
    check_val("rst_run", 64'(running), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // ch0 up-wrap, one tick per cycle, wrap after 256 ticks
    wr(0, SelCtrl, 8'b001);
    step("t1_en", 0, 8'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 256; k++) step("t1_up", 0, 8'(k % 256), (k == 256), 1'b1);
    wr(0, SelCtrl, 8'b000);
    step("t1_stop", 0, 8'd1, 1'b0, 1'b0);

    // ch1 up-mod, prescale 2, limit 4: 15-cycle period
    wr_now(1, SelPrescale, 8'd2);
    wr_now(1, SelLimit, 8'd4);
    wr(1, SelCtrl, 8'b101);
    step("t2_en", 1, 8'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 30; k++) step("t2_mod", 1, 8'((k / 3) % 5), ((k % 15) == 0), 1'b1);
    wr(1, SelCtrl, 8'b000);
    step("t2_stop", 1, 8'd0, 1'b0, 1'b0);

    // ch2 one-shot to limit 3
    wr_now(2, SelLimit, 8'd3);
    wr(2, SelCtrl, 8'b111);
    step("t3_en", 2, 8'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) step("t3_up", 2, 8'(k), 1'b0, 1'b1);
    step("t3_done", 2, 8'd3, 1'b1, 1'b0);
    step("t3_hold", 2, 8'd3, 1'b0, 1'b0);
    step("t3_hold", 2, 8'd3, 1'b0, 1'b0);

    // ch3 down-wrap from 5, then loads on tick cycles
    wr_now(3, SelLoad, 8'd5);
    wr(3, SelCtrl, 8'b011);
    step("t4_en", 3, 8'd5, 1'b0, 1'b1);
    dn_seq = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd255, 8'd254};
    for (int k = 0; k < 7; k++) step("t4_dn", 3, dn_seq[k], (dn_seq[k] == 8'd255), 1'b1);
    wr(3, SelLoad, 8'd100);
    step("t4_load", 3, 8'd100, 1'b0, 1'b1);
    step("t4_dn2", 3, 8'd99, 1'b0, 1'b1);
    wr(3, SelLoad, 8'd0);
    step("t4_load0", 3, 8'd0, 1'b0, 1'b1);
    wr(3, SelLoad, 8'd100);
    step("t4_ldwrap", 3, 8'd100, 1'b0, 1'b1);
    step("t4_dn3", 3, 8'd99, 1'b0, 1'b1);
    wr(3, SelCtrl, 8'b000);
    step("t4_stop", 3, 8'd98, 1'b0, 1'b0);

    // ch0 up-mod at 10, limit lowered below the count
    wr_now(0, SelLoad, 8'd10);
    wr_now(0, SelLimit, 8'd20);
    wr(0, SelCtrl, 8'b101);
    step("t5_en", 0, 8'd10, 1'b0, 1'b1);
    wr(0, SelLimit, 8'd6);
    step("t5_oldlim", 0, 8'd11, 1'b0, 1'b1);
    step("t5_wrap", 0, 8'd0, 1'b1, 1'b1);
    step("t5_up", 0, 8'd1, 1'b0, 1'b1);
    wr(5, SelLoad, 8'd77);
    step("t5_bad_ld", 0, 8'd2, 1'b0, 1'b1);
    wr(5, SelCtrl, 8'b001);
    step("t5_bad_ctl", 0, 8'd3, 1'b0, 1'b1);
    check_val("t5_ch4_cnt", 64'(out[4*W +: W]), 64'd0);
    check_val("t5_run_vec", 64'(running), 64'd1);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    check_val("t6_out", 64'(out), 64'd0);
    check_val("t6_tc", 64'(tc), 64'd0);
    check_val("t6_run", 64'(running), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("t6_idle", 0, 8'd0, 1'b0, 1'b0);
    step("t6_idle", 0, 8'd0, 1'b0, 1'b0);
    check_val("t6_idle_out", 64'(out), 64'd0);
    wr(0, SelCtrl, 8'b001);
    step("t6_en", 0, 8'd0, 1'b0, 1'b1);
    step("t6_up", 0, 8'd1, 1'b0, 1'b1);

    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
